// File: rtl/attenuator_if.sv
// Sample/result handshake bundle for the attenuator: upstream sample + gain in, quotient out.
interface attenuator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int GAIN_WIDTH = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic [GAIN_WIDTH-1:0] i_gain;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_div_by_zero;

  modport master (
    output i_valid, i_data, i_gain, i_ready,
    input  o_ready, o_valid, o_data, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_data, i_gain, i_ready,
    output o_ready, o_valid, o_data, o_div_by_zero
  );
endinterface

// File: rtl/attenuator.sv
// Signed sample / unsigned gain via bit-serial restoring divide; fixed DATA_WIDTH-cycle latency,
// accepts only in IDLE and holds the registered result until downstream takes it (no skid).
module attenuator #(
  parameter int DATA_WIDTH = 8,
  parameter int GAIN_WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  attenuator_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  neg_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [GAIN_WIDTH:0]   rem_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  dbz_q;

  logic [DATA_WIDTH-1:0] mag_d;
  logic [GAIN_WIDTH+1:0] rem_sh;
  logic [GAIN_WIDTH+1:0] diff;
  logic                  borrow;
  logic [GAIN_WIDTH:0]   rem_d;
  logic [DATA_WIDTH-1:0] dvd_d;
  logic [DATA_WIDTH-1:0] quo_signed;
  logic [DATA_WIDTH-1:0] result_d;

  // Magnitude of the most negative sample wraps to 2^(DATA_WIDTH-1), which is exact as unsigned.
  assign mag_d = bus.i_data[DATA_WIDTH-1] ? (~bus.i_data + DATA_WIDTH'(1)) : bus.i_data;

  // One restoring step: dividend bits leave dvd_q at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh     = {rem_q, dvd_q[DATA_WIDTH-1]};
    diff       = rem_sh - {2'b00, gain_q};
    borrow     = diff[GAIN_WIDTH+1];
    rem_d      = borrow ? rem_sh[GAIN_WIDTH:0] : diff[GAIN_WIDTH:0];
    dvd_d      = {dvd_q[DATA_WIDTH-2:0], ~borrow};
    quo_signed = neg_q ? (~dvd_d + DATA_WIDTH'(1)) : dvd_d;
    result_d   = quo_signed;
    if (gain_q == '0) begin
      if (zero_q) begin
        result_d = '0;
      end else if (neg_q) begin
        result_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        result_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      dvd_q   <= '0;
      gain_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            neg_q   <= bus.i_data[DATA_WIDTH-1];
            zero_q  <= (bus.i_data == '0);
            dvd_q   <= mag_d;
            gain_q  <= bus.i_gain;
            cnt_q   <= CNT_W'(DATA_WIDTH - 1);
            rem_q   <= '0;
            ready_q <= 1'b0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            valid_q <= 1'b1;
            data_q  <= result_d;
            dbz_q   <= (gain_q == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_data        = data_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_attenuator.sv
// Directed bench for attenuator: transaction-level reference model plus hand-computed literal results.
module tb_attenuator;

  localparam int DW = 8;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attenuator_if #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) bus ();

  attenuator #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b0;

  // Reference model state: what the outputs must read after each edge.
  bit m_ready, m_valid, m_dbz, m_pdbz;
  int m_data, m_pend, m_left;

  function automatic int ref_div(input int d, input int g);
    if (g == 0) return (d > 0) ? 127 : ((d < 0) ? -128 : 0);
    return d / g;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b1; m_valid = 1'b0; m_data = 0; m_dbz = 1'b0; m_left = 0;
    end else if (m_ready && bus.i_valid) begin
      m_pend  = ref_div($signed(bus.i_data), int'(bus.i_gain));
      m_pdbz  = (bus.i_gain == 0);
      m_left  = DW;
      m_ready = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1; m_data = m_pend; m_dbz = m_pdbz;
      end
    end else if (m_valid && bus.i_ready) begin
      m_valid = 1'b0; m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_o_ready", bus.o_ready, m_ready);
      chk("model_o_valid", bus.o_valid, m_valid);
      chk("model_o_data", $signed(bus.o_data), m_data);
      if (m_valid) chk("model_o_div_by_zero", bus.o_div_by_zero, m_dbz);
    end
  end

  task automatic run_div(input int d, input int g, input int lit, input int lit_dbz, input int hold);
    int lat;
    bit prev_rdy;
    lat = 0;
    while (!bus.o_ready && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("wait_ready", bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_data  = d[7:0];
    bus.i_gain  = g[7:0];
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'($urandom);
    bus.i_gain  = 8'($urandom);
    lat = 0;
    while (!bus.o_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
      if (lat == 3) begin
        bus.i_data = 8'($urandom);
        bus.i_gain = 8'($urandom);
      end
    end
    chk("latency", lat, 8);
    chk("result", $signed(bus.o_data), lit);
    chk("div_by_zero", bus.o_div_by_zero, lit_dbz);
    prev_rdy = bus.i_ready;
    if (!prev_rdy) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_data", $signed(bus.o_data), lit);
        chk("hold_ready", bus.o_ready, 0);
      end
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("accept_ready", bus.o_ready, 1);
    chk("accept_valid", bus.o_valid, 0);
    chk("accept_data_kept", $signed(bus.o_data), lit);
    bus.i_ready = prev_rdy;
  endtask

  int tp_d[3]   = '{20, -90, 64};
  int tp_g[3]   = '{3, 7, 0};
  int tp_exp[3] = '{6, -12, 127};

  initial begin
    int idx, nres, cyc;
    int rise[3];
    bit seen_valid, prev_v;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    bus.i_gain  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("reset_ready", bus.o_ready, 1);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_data", $signed(bus.o_data), 0);
    chk("reset_dbz", bus.o_div_by_zero, 0);

    bus.i_ready = 1'b1;
    run_div(100, 4, 25, 0, 0);
    run_div(127, 127, 1, 0, 0);
    run_div(7, 8, 0, 0, 0);
    run_div(-100, 3, -33, 0, 0);
    run_div(-128, 1, -128, 0, 0);
    run_div(-128, 255, 0, 0, 0);
    run_div(-1, 2, 0, 0, 0);
    run_div(127, 0, 127, 1, 0);
    run_div(-5, 0, -128, 1, 0);
    run_div(0, 0, 0, 1, 0);

    bus.i_ready = 1'b0;
    run_div(50, 5, 10, 0, 6);

    // Abort a divide part-way through with reset.
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd90;
    bus.i_gain  = 8'd9;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_data", $signed(bus.o_data), 0);
    seen_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen_valid = 1'b1;
    end
    chk("abort_no_result", seen_valid, 0);
    run_div(90, 9, 10, 0, 0);

    // Back-to-back with i_valid and i_ready tied high; inputs churn while busy.
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    idx = 0; nres = 0; cyc = 0; prev_v = bus.o_valid;
    while (nres < 3 && cyc < 60) begin
      if (bus.o_ready && idx < 3) begin
        bus.i_data = tp_d[idx][7:0];
        bus.i_gain = tp_g[idx][7:0];
        idx++;
      end else if (idx >= 3 && bus.o_ready) begin
        bus.i_valid = 1'b0;
      end else begin
        bus.i_data = 8'($urandom);
        bus.i_gain = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.o_valid && !prev_v) begin
        rise[nres] = cyc;
        chk("tput_result", $signed(bus.o_data), tp_exp[nres]);
        nres++;
      end
      prev_v = bus.o_valid;
    end
    bus.i_valid = 1'b0;
    chk("tput_count", nres, 3);
    if (nres == 3) begin
      chk("tput_period_1", rise[1] - rise[0], 10);
      chk("tput_period_2", rise[2] - rise[1], 10);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
